// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze sequencer: arms on enable and rings on a rising time match.
// Handles snooze countdown, auto-silence timeout and a 1 Hz buzz blink.
module alarm_sequencer #(
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 2,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       enable,
  input  logic       match,
  input  logic       sec,
  input  logic       min,
  input  logic       stop,
  input  logic       snooze,
  output logic       ring,
  output logic       buzz,
  output logic       snoozing,
  output logic [1:0] state,
  output logic [2:0] snooze_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    RINGING = 2'b10,
    SNOOZE  = 2'b11
  } state_t;

  state_t     st;
  logic       match_q;
  logic       match_rise;
  logic       toggle;
  logic       can_snooze;
  logic [5:0] ring_tmr;
  logic [5:0] ring_inc;
  logic [5:0] snz_tmr;

  assign match_rise = match & ~match_q;
  assign can_snooze = snooze_cnt < 3'(MAX_SNOOZE);
  assign ring_inc   = (ring_tmr == 6'd63) ? 6'd63 : ring_tmr + 6'd1;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      match_q    <= 1'b0;
      toggle     <= 1'b0;
      ring_tmr   <= '0;
      snz_tmr    <= '0;
      snooze_cnt <= '0;
    end else begin
      match_q <= match;
      if (!enable) begin
        st         <= IDLE;
        toggle     <= 1'b0;
        ring_tmr   <= '0;
        snz_tmr    <= '0;
        snooze_cnt <= '0;
      end else begin
        unique case (st)
          IDLE: st <= ARMED;
          ARMED: begin
            if (match_rise) begin
              st       <= RINGING;
              ring_tmr <= '0;
              toggle   <= 1'b1;
            end
          end
          RINGING: begin
            if (sec) toggle <= ~toggle;
            // a user action in the same cycle masks the minute tick
            if (stop) begin
              st         <= ARMED;
              ring_tmr   <= '0;
              snooze_cnt <= '0;
            end else if (snooze && can_snooze) begin
              st         <= SNOOZE;
              snz_tmr    <= 6'(SNOOZE_MIN);
              snooze_cnt <= snooze_cnt + 3'd1;
            end else if (min) begin
              if (ring_inc >= 6'(RING_TIMEOUT_MIN)) begin
                st         <= ARMED;
                ring_tmr   <= '0;
                snooze_cnt <= '0;
              end else begin
                ring_tmr <= ring_inc;
              end
            end
          end
          SNOOZE: begin
            if (stop) begin
              st         <= ARMED;
              snz_tmr    <= '0;
              snooze_cnt <= '0;
            end else if (min) begin
              if (snz_tmr == 6'd1) begin
                st       <= RINGING;
                snz_tmr  <= '0;
                ring_tmr <= '0;
                toggle   <= 1'b1;
              end else if (snz_tmr != 6'd0) begin
                snz_tmr <= snz_tmr - 6'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign state    = st;
  assign ring     = (st == RINGING);
  assign buzz     = ring & toggle;
  assign snoozing = (st == SNOOZE);

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed vector bench for alarm_sequencer with default parameters.
// Inputs packed {enable,match,sec,min,stop,snooze}; outputs {state,ring,buzz,snoozing,cnt}.
module tb_alarm_sequencer;

  logic       ck = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       match = 1'b0;
  logic       sec = 1'b0;
  logic       min = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       ring;
  logic       buzz;
  logic       snoozing;
  logic [1:0] state;
  logic [2:0] snooze_cnt;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    string      name;
    logic [5:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  alarm_sequencer dut (
    .ck(ck),
    .reset(reset),
    .enable(enable),
    .match(match),
    .sec(sec),
    .min(min),
    .stop(stop),
    .snooze(snooze),
    .ring(ring),
    .buzz(buzz),
    .snoozing(snoozing),
    .state(state),
    .snooze_cnt(snooze_cnt)
  );

  always #5 ck = ~ck;

  function automatic logic [7:0] e8(input logic [1:0] s, input logic r,
                                    input logic b, input logic z,
                                    input logic [2:0] c);
    return {s, r, b, z, c};
  endfunction

  task automatic add(input string n, input logic [5:0] i, input logic [7:0] e);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string n, input logic [7:0] e);
    logic [7:0] got;
    got = {state, ring, buzz, snoozing, snooze_cnt};
    nvec++;
    if (got !== e) begin
      nbad++;
      $display("FAIL %s: got %b expected %b", n, got, e);
    end
  endtask

  task automatic step(input string n, input logic [5:0] i, input logic [7:0] e);
    {enable, match, sec, min, stop, snooze} = i;
    @(posedge ck);
    #1;
    check(n, e);
  endtask

  initial begin
    // vectors applied in order from the post-reset IDLE state
    add("arm",      6'b100000, e8(2'd1, 0, 0, 0, 3'd0));
    add("rise",     6'b110000, e8(2'd2, 1, 1, 0, 3'd0));
    add("sec1",     6'b111000, e8(2'd2, 1, 0, 0, 3'd0));
    add("sec2",     6'b111000, e8(2'd2, 1, 1, 0, 3'd0));
    add("min1",     6'b110100, e8(2'd2, 1, 1, 0, 3'd0));
    add("timeout",  6'b110100, e8(2'd1, 0, 0, 0, 3'd0));
    add("hold",     6'b110000, e8(2'd1, 0, 0, 0, 3'd0));
    add("mlow",     6'b100000, e8(2'd1, 0, 0, 0, 3'd0));
    add("rise2",    6'b110000, e8(2'd2, 1, 1, 0, 3'd0));
    add("snz",      6'b110001, e8(2'd3, 0, 0, 1, 3'd1));
    add("sm4",      6'b110100, e8(2'd3, 0, 0, 1, 3'd1));
    add("sm3",      6'b110100, e8(2'd3, 0, 0, 1, 3'd1));
    add("sm2",      6'b110100, e8(2'd3, 0, 0, 1, 3'd1));
    add("sm1",      6'b110100, e8(2'd3, 0, 0, 1, 3'd1));
    add("rering",   6'b110100, e8(2'd2, 1, 1, 0, 3'd1));
    add("snz_min",  6'b110101, e8(2'd3, 0, 0, 1, 3'd2));
    add("snz_ign",  6'b110001, e8(2'd3, 0, 0, 1, 3'd2));
    add("stop_min", 6'b110110, e8(2'd1, 0, 0, 0, 3'd0));
    add("mlow2",    6'b100000, e8(2'd1, 0, 0, 0, 3'd0));
    add("rise3",    6'b110000, e8(2'd2, 1, 1, 0, 3'd0));
    add("rmin",     6'b110100, e8(2'd2, 1, 1, 0, 3'd0));
    add("snz1",     6'b110001, e8(2'd3, 0, 0, 1, 3'd1));

    #2 reset = 1'b1;
    #1 check("reset_async", e8(2'd0, 0, 0, 0, 3'd0));
    repeat (2) @(posedge ck);
    #1 check("reset_hold", e8(2'd0, 0, 0, 0, 3'd0));
    reset = 1'b0;

    foreach (tbl[k]) step(tbl[k].name, tbl[k].in, tbl[k].exp);

    // walk snoozes up to the limit; ring timer must restart on each re-ring
    for (int c = 1; c <= 3; c++) begin
      for (int i = 0; i < 4; i++)
        step("count", 6'b110100, e8(2'd3, 0, 0, 1, 3'(c)));
      step("rering_n", 6'b110100, e8(2'd2, 1, 1, 0, 3'(c)));
      if (c == 1) step("rt_clear", 6'b110100, e8(2'd2, 1, 1, 0, 3'd1));
      if (c < 3) step("snz_n", 6'b110001, e8(2'd3, 0, 0, 1, 3'(c + 1)));
    end
    step("snz_max", 6'b110001, e8(2'd2, 1, 1, 0, 3'd3));
    step("stop_max", 6'b110010, e8(2'd1, 0, 0, 0, 3'd0));

    step("b_mlow", 6'b100000, e8(2'd1, 0, 0, 0, 3'd0));
    step("b_rise", 6'b110000, e8(2'd2, 1, 1, 0, 3'd0));
    step("stop_snz", 6'b110011, e8(2'd1, 0, 0, 0, 3'd0));

    step("c_mlow", 6'b100000, e8(2'd1, 0, 0, 0, 3'd0));
    step("c_rise", 6'b110000, e8(2'd2, 1, 1, 0, 3'd0));
    step("disable", 6'b010000, e8(2'd0, 0, 0, 0, 3'd0));
    step("dis_hold", 6'b010000, e8(2'd0, 0, 0, 0, 3'd0));
    step("en_match", 6'b110000, e8(2'd1, 0, 0, 0, 3'd0));
    step("no_ring", 6'b110000, e8(2'd1, 0, 0, 0, 3'd0));
    step("m_fall", 6'b100000, e8(2'd1, 0, 0, 0, 3'd0));
    step("m_rise", 6'b110000, e8(2'd2, 1, 1, 0, 3'd0));

    step("d_snz", 6'b110001, e8(2'd3, 0, 0, 1, 3'd1));
    step("d_min", 6'b110100, e8(2'd3, 0, 0, 1, 3'd1));
    @(negedge ck);
    #2 reset = 1'b1;
    #1 check("rst_snooze", e8(2'd0, 0, 0, 0, 3'd0));
    @(posedge ck);
    #1 check("rst_held", e8(2'd0, 0, 0, 0, 3'd0));
    @(negedge ck);
    reset = 1'b0;
    #1 check("rst_release", e8(2'd0, 0, 0, 0, 3'd0));
    step("post_arm", 6'b110000, e8(2'd1, 0, 0, 0, 3'd0));
    step("post_hold", 6'b110000, e8(2'd1, 0, 0, 0, 3'd0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter SNOOZE_MIN, default 5, minutes from snooze request to re-ring; legal range 1..63.
REQ-002 Parameter RING_TIMEOUT_MIN, default 2, minutes of unattended ringing before auto-silence; legal range 1..63.
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event; legal range 0..7.
REQ-004 ck  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  alarm armed switch, already debounced (level).
REQ-007 match  input  1  level, high while displayed time equals alarm time.
REQ-008 sec  input  1  one-cycle pulse per second.
REQ-009 min  input  1  one-cycle pulse per minute.
REQ-010 stop  input  1  one-cycle pulse, user dismisses alarm.
REQ-011 snooze  input  1  one-cycle pulse, user requests snooze.
REQ-012 ring  output  1  high in RINGING.
REQ-013 buzz  output  1  audible drive; ring gated by 1 Hz toggle.
REQ-014 snoozing  output  1  high in SNOOZE.
REQ-015 state  output  2  encoded FSM state.
REQ-016 snooze_cnt  output  3  snoozes used in current alarm event.

Function
REQ-017 FSM states SHALL be IDLE=00, ARMED=01, RINGING=10, SNOOZE=11; all outputs registered or decoded from registered state only.
REQ-018 match SHALL be registered into match_q each cycle; match_rise = match & ~match_q.
REQ-019 enable=0 SHALL force IDLE on next edge from any state, clearing ring timer, snooze timer and snooze_cnt; highest priority after reset.
REQ-020 IDLE with enable=1 SHALL go to ARMED next edge.
REQ-021 ARMED with match_rise SHALL go to RINGING, ring timer cleared, snooze_cnt unchanged (0 on fresh event).
REQ-022 ARMED entered while match already high SHALL NOT ring until match falls and rises again.
REQ-023 RINGING: stop SHALL go to ARMED and clear snooze_cnt.
REQ-024 RINGING: snooze with snooze_cnt < MAX_SNOOZE SHALL go to SNOOZE, load snooze timer with SNOOZE_MIN, increment snooze_cnt.
REQ-025 RINGING: snooze with snooze_cnt = MAX_SNOOZE SHALL be ignored (stays RINGING).
REQ-026 RINGING: each min pulse SHALL increment 6-bit ring timer; when the increment reaches RING_TIMEOUT_MIN, go to ARMED and clear snooze_cnt.
REQ-027 RINGING: stop and snooze same cycle -> stop wins; stop or snooze together with min -> stop/snooze wins, min ignored.
REQ-028 SNOOZE: each min pulse SHALL decrement 6-bit snooze timer; on min pulse with timer=1, go to RINGING with ring timer cleared.
REQ-029 SNOOZE: stop SHALL go to ARMED, clear snooze timer and snooze_cnt; snooze pulses ignored; stop with min same cycle -> stop wins.
REQ-030 Timers SHALL never wrap: ring timer saturates at 63, snooze timer holds at 0.
REQ-031 Blink toggle SHALL be set to 1 on every entry to RINGING and invert on each sec pulse while RINGING; buzz = ring & toggle.
REQ-032 sec, min, stop, snooze SHALL each be consumed as single-cycle events; a level held multiple cycles counts once per high cycle.

Reset
REQ-033 reset=1 SHALL immediately force state=IDLE, ring=0, buzz=0, snoozing=0, snooze_cnt=0, both timers 0, toggle=0, match_q=0.
REQ-034 Deassertion SHALL leave the block in IDLE; first transition earliest on the next rising edge.
REQ-035 reset asserted mid-RINGING or mid-SNOOZE SHALL drop ring/buzz/snoozing without waiting for ck.

Verification
REQ-036 enable=1, match rises -> state 01 then 10; ring=1, buzz=1 one cycle after entry; buzz toggles per sec pulse.
REQ-037 RINGING, 2 min pulses, no user input (RING_TIMEOUT_MIN=2) -> state 01 after second pulse; ring=0, snooze_cnt=0.
REQ-038 RINGING, snooze pulse, 5 min pulses -> snoozing=1, snooze_cnt=1, RINGING re-entered exactly after fifth min pulse.
REQ-039 Fourth snooze attempt with MAX_SNOOZE=3 -> ignored, stays RINGING, snooze_cnt=3; then stop -> ARMED, snooze_cnt=0.
REQ-040 enable raised while match already high -> ARMED, no ring; match low then high -> RINGING.
REQ-041 reset pulsed mid-SNOOZE, asynchronous to ck -> outputs 0 immediately; stop+snooze same cycle in RINGING -> ARMED.
